slc3_control: RTL

// - Instruction sequencer for the SLC3 datapath. A Moore FSM drives the datapath's

---
 rtl/slc3_control.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/slc3_control.sv
// rtl/slc3_control.sv - SLC3 Moore-FSM instruction sequencer (optional PAUSE states under SLC3_PAUSE_EN)
module slc3_control #(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [4:0]  State_dbg
);

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR, S_JSR2,
        S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_STR3,
        S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    state_t     state, next_state;
    logic [2:0] wait_cnt;
    logic       wait_done;
    logic       enter_wait;
    logic       unused_inputs;

    assign wait_done     = (wait_cnt == 3'd0);
    assign enter_wait    = (next_state != state) && (next_state inside {S_F2, S_LDR2, S_STR3});
    assign State_dbg     = state;
    assign unused_inputs = ^{Continue, IR[11:6], IR[4:0]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_HALTED;
            wait_cnt <= 3'd0;
        end else begin
            state <= next_state;
            if (enter_wait)
                wait_cnt <= WAIT_INIT;
            else if (!wait_done)
                wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_comb begin
        next_state = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state)
            S_HALTED: if (Run) next_state = S_F1;
            S_F1: begin
                GatePC     = 1'b1;
                LD_MAR     = 1'b1;
                LD_PC      = 1'b1;
                next_state = S_F2;
            end
            S_F2, S_LDR2: begin
                Mem_OE = 1'b1;
                MIO_EN = 1'b1;
                // MDR captures only once the memory has had its wait states
                if (wait_done) begin
                    LD_MDR     = 1'b1;
                    next_state = (state == S_F2) ? S_F3 : S_LDR3;
                end
            end
            S_F3: begin
                GateMDR    = 1'b1;
                LD_IR      = 1'b1;
                next_state = S_DEC;
            end
            S_DEC: begin
                LD_BEN = 1'b1;
                case (IR[15:12])
                    4'b0001: next_state = S_ADD;
                    4'b0101: next_state = S_AND;
                    4'b1001: next_state = S_NOT;
                    4'b0000: next_state = S_BR;
                    4'b1100: next_state = S_JMP;
                    4'b0100: next_state = S_JSR;
                    4'b0110: next_state = S_LDR1;
                    4'b0111: next_state = S_STR1;
`ifdef SLC3_PAUSE_EN
                    4'b1101: next_state = S_PAUSE1;
`endif
                    default: next_state = S_F1;
                endcase
            end
            S_ADD, S_AND: begin
                SR1MUX     = 1'b1;
                SR2MUX     = IR[5];
                ALUK       = (state == S_AND) ? 2'b01 : 2'b00;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S_F1;
            end
            S_NOT: begin
                SR1MUX     = 1'b1;
                ALUK       = 2'b10;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S_F1;
            end
            S_BR: next_state = BEN ? S_BR_T : S_F1;
            S_BR_T: begin
                ADDR2MUX   = 2'b10;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                next_state = S_F1;
            end
            S_JMP: begin
                SR1MUX     = 1'b1;
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                PCMUX      = 2'b01;
                LD_PC      = 1'b1;
                next_state = S_F1;
            end
            // PC was already incremented in F1, so R7 gets the return address
            S_JSR: begin
                GatePC     = 1'b1;
                DRMUX      = 1'b1;
                LD_REG     = 1'b1;
                next_state = S_JSR2;
            end
            S_JSR2: begin
                ADDR2MUX   = 2'b11;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                next_state = S_F1;
            end
            S_LDR1, S_STR1: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                next_state = (state == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR3: begin
                GateMDR    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S_F1;
            end
            S_STR2: begin
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                LD_MDR     = 1'b1;
                next_state = S_STR3;
            end
            S_STR3: begin
                Mem_WE = 1'b1;
                if (wait_done) next_state = S_F1;
            end
`ifdef SLC3_PAUSE_EN
            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) next_state = S_PAUSE2;
            end
            S_PAUSE2: if (!Continue) next_state = S_F1;
`endif
            default: next_state = S_HALTED;
        endcase
    end

endmodule
